// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: controller state encoding, fixed opcodes and the
// IR capture pattern.
package jtag_tap_pkg;

  // The 16 IEEE 1149.1 controller states, using the customary 4-bit encoding.
  typedef enum logic [3:0] {
    ST_EXIT2_DR   = 4'h0,
    ST_EXIT1_DR   = 4'h1,
    ST_SHIFT_DR   = 4'h2,
    ST_PAUSE_DR   = 4'h3,
    ST_SELECT_IR  = 4'h4,
    ST_UPDATE_DR  = 4'h5,
    ST_CAPTURE_DR = 4'h6,
    ST_SELECT_DR  = 4'h7,
    ST_EXIT2_IR   = 4'h8,
    ST_EXIT1_IR   = 4'h9,
    ST_SHIFT_IR   = 4'hA,
    ST_PAUSE_IR   = 4'hB,
    ST_RUN_IDLE   = 4'hC,
    ST_UPDATE_IR  = 4'hD,
    ST_CAPTURE_IR = 4'hE,
    ST_TEST_RESET = 4'hF
  } tap_state_e;

  localparam logic [5:0]  IDCODE_OP  = 6'h09;
  localparam logic [5:0]  BYPASS_OP  = 6'h3F;
  // Low bits loaded into the IR shift register on CAPTURE-IR; upper bits are 0.
  localparam logic [1:0]  IR_CAPTURE = 2'b01;
  localparam int unsigned IDCODE_LEN = 32;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller: state register and tms-driven next-state logic.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state_q,
  output tap_state_e next_state_c
);

  tap_state_e state_d;

  // Standard 1149.1 transitions; five tms=1 rises reach TEST-LOGIC-RESET.
  always_comb begin
    state_d = ST_TEST_RESET;
    case (state_q)
      ST_TEST_RESET: state_d = tms ? ST_TEST_RESET : ST_RUN_IDLE;
      ST_RUN_IDLE:   state_d = tms ? ST_SELECT_DR  : ST_RUN_IDLE;
      ST_SELECT_DR:  state_d = tms ? ST_SELECT_IR  : ST_CAPTURE_DR;
      ST_CAPTURE_DR: state_d = tms ? ST_EXIT1_DR   : ST_SHIFT_DR;
      ST_SHIFT_DR:   state_d = tms ? ST_EXIT1_DR   : ST_SHIFT_DR;
      ST_EXIT1_DR:   state_d = tms ? ST_UPDATE_DR  : ST_PAUSE_DR;
      ST_PAUSE_DR:   state_d = tms ? ST_EXIT2_DR   : ST_PAUSE_DR;
      ST_EXIT2_DR:   state_d = tms ? ST_UPDATE_DR  : ST_SHIFT_DR;
      ST_UPDATE_DR:  state_d = tms ? ST_SELECT_DR  : ST_RUN_IDLE;
      ST_SELECT_IR:  state_d = tms ? ST_TEST_RESET : ST_CAPTURE_IR;
      ST_CAPTURE_IR: state_d = tms ? ST_EXIT1_IR   : ST_SHIFT_IR;
      ST_SHIFT_IR:   state_d = tms ? ST_EXIT1_IR   : ST_SHIFT_IR;
      ST_EXIT1_IR:   state_d = tms ? ST_UPDATE_IR  : ST_PAUSE_IR;
      ST_PAUSE_IR:   state_d = tms ? ST_EXIT2_IR   : ST_PAUSE_IR;
      ST_EXIT2_IR:   state_d = tms ? ST_UPDATE_IR  : ST_SHIFT_IR;
      ST_UPDATE_IR:  state_d = tms ? ST_SELECT_DR  : ST_RUN_IDLE;
      default:       state_d = ST_TEST_RESET;
    endcase
  end

  // State register, forced to TEST-LOGIC-RESET asynchronously.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) state_q <= ST_TEST_RESET;
    else     state_q <= state_d;
  end

  assign next_state_c = state_d;

endmodule

// File: rtl/jtag_user_tap.sv
// JTAG TAP with IDCODE, BYPASS and four user-chain instructions. The IR and
// internal DRs live here; user chains are external and only muxed onto tdo.
module jtag_user_tap
  import jtag_tap_pkg::*;
#(
  parameter int unsigned       IR_LEN     = 6,
  parameter logic [31:0]       IDCODE_VAL = 32'h0362_D093,
  parameter logic [IR_LEN-1:0] USER1      = IR_LEN'(6'h02),
  parameter logic [IR_LEN-1:0] USER2      = IR_LEN'(6'h03),
  parameter logic [IR_LEN-1:0] USER3      = IR_LEN'(6'h22),
  parameter logic [IR_LEN-1:0] USER4      = IR_LEN'(6'h23)
) (
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  input  logic       tdi,
  input  logic [3:0] user_tdo,
  output logic       tdo,
  output logic       tdo_en,
  output logic       capture,
  output logic       shift,
  output logic       update,
  output logic       tlr_reset,
  output logic       runtest,
  output logic [3:0] sel
);

  localparam logic [IR_LEN-1:0] IDCODE_IR  = IR_LEN'(IDCODE_OP);
  localparam logic [IR_LEN-1:0] BYPASS_IR  = IR_LEN'(BYPASS_OP);
  localparam logic [IR_LEN-1:0] CAPTURE_IR = IR_LEN'(IR_CAPTURE);

  tap_state_e state_q, state_d;

  logic [IR_LEN-1:0]     ir_sr_q, ir_sr_d;
  logic [IR_LEN-1:0]     ir_q, ir_d;
  logic [IDCODE_LEN-1:0] id_sr_q, id_sr_d;
  logic                  byp_q, byp_d;
  logic [3:0]            sel_q, sel_d;
  logic                  capture_q, capture_d, shift_q, shift_d;
  logic                  update_q, update_d, tlr_reset_q, tlr_reset_d;
  logic                  runtest_q, runtest_d, tdo_en_q, tdo_en_d;
  logic                  tdo_q, tdo_d;
  logic                  dr_idcode_c, dr_user_c, dr_bypass_c;

  jtag_tap_fsm u_fsm (
    .tck          (tck),
    .rst          (rst),
    .tms          (tms),
    .state_q      (state_q),
    .next_state_c (state_d)
  );

  // DR selection from the active IR; anything unrecognised falls to bypass.
  always_comb begin
    dr_idcode_c = (ir_q == IDCODE_IR);
    dr_user_c   = |sel_q;
    dr_bypass_c = (ir_q == BYPASS_IR) || !(dr_idcode_c || dr_user_c);
  end

  // IR/DR capture, shift and update actions for the current state.
  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    id_sr_d = id_sr_q;
    byp_d   = byp_q;
    case (state_q)
      ST_CAPTURE_IR: ir_sr_d = CAPTURE_IR;
      ST_SHIFT_IR:   ir_sr_d = {tdi, ir_sr_q[IR_LEN-1:1]};
      ST_UPDATE_IR:  ir_d    = ir_sr_q;
      ST_CAPTURE_DR: begin
        if (dr_idcode_c) id_sr_d = IDCODE_VAL;
        if (dr_bypass_c) byp_d   = 1'b0;
      end
      ST_SHIFT_DR: begin
        if (dr_idcode_c) id_sr_d = {tdi, id_sr_q[IDCODE_LEN-1:1]};
        if (dr_bypass_c) byp_d   = tdi;
      end
      default: ;
    endcase
    // Entering or staying in TEST-LOGIC-RESET reselects IDCODE.
    if (state_d == ST_TEST_RESET) ir_d = IDCODE_IR;
  end

  // State-decoded flags registered from the next state so they track state_q.
  always_comb begin
    capture_d   = (state_d == ST_CAPTURE_DR);
    shift_d     = (state_d == ST_SHIFT_DR);
    update_d    = (state_d == ST_UPDATE_DR);
    tlr_reset_d = (state_d == ST_TEST_RESET);
    runtest_d   = (state_d == ST_RUN_IDLE);
    tdo_en_d    = (state_d == ST_SHIFT_DR) || (state_d == ST_SHIFT_IR);
    sel_d       = {ir_d == USER4, ir_d == USER3, ir_d == USER2, ir_d == USER1};
  end

  // Rising-edge registers.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      ir_sr_q     <= '0;
      ir_q        <= IDCODE_IR;
      id_sr_q     <= '0;
      byp_q       <= 1'b0;
      sel_q       <= 4'b0000;
      capture_q   <= 1'b0;
      shift_q     <= 1'b0;
      update_q    <= 1'b0;
      tlr_reset_q <= 1'b1;
      runtest_q   <= 1'b0;
      tdo_en_q    <= 1'b0;
    end else begin
      ir_sr_q     <= ir_sr_d;
      ir_q        <= ir_d;
      id_sr_q     <= id_sr_d;
      byp_q       <= byp_d;
      sel_q       <= sel_d;
      capture_q   <= capture_d;
      shift_q     <= shift_d;
      update_q    <= update_d;
      tlr_reset_q <= tlr_reset_d;
      runtest_q   <= runtest_d;
      tdo_en_q    <= tdo_en_d;
    end
  end

  // Serial output source: LSB of the selected register, 0 outside shifts.
  always_comb begin
    tdo_d = 1'b0;
    if (state_q == ST_SHIFT_IR) begin
      tdo_d = ir_sr_q[0];
    end else if (state_q == ST_SHIFT_DR) begin
      if (dr_idcode_c)      tdo_d = id_sr_q[0];
      else if (dr_bypass_c) tdo_d = byp_q;
      else                  tdo_d = |(user_tdo & sel_q);
    end
  end

  // tdo changes on the falling edge so it is stable at the next rise.
  always_ff @(negedge tck or posedge rst) begin
    if (rst) tdo_q <= 1'b0;
    else     tdo_q <= tdo_d;
  end

  assign tdo       = tdo_q;
  assign tdo_en    = tdo_en_q;
  assign capture   = capture_q;
  assign shift     = shift_q;
  assign update    = update_q;
  assign tlr_reset = tlr_reset_q;
  assign runtest   = runtest_q;
  assign sel       = sel_q;

endmodule
